// File: rtl/rvv_backend_dispatch_uop_seq_if.sv
// Shared types and the port bundle for the dispatch uop sequencer.
//
// rvv_uop_seq_pkg : operand EEW and execution-unit encodings.
// rvv_backend_dispatch_uop_seq_if : descriptor handshake (inst_*), the v0
//   value, the flush kill, the uop handshake with its payload (uop_*), and busy.
//   modport slave  : the sequencer's view. It takes descriptors and presents uops.
//   modport master : the surrounding logic's view. It supplies descriptors and
//                    takes uops.
package rvv_uop_seq_pkg;
  typedef enum logic [1:0] {
    EEW8  = 2'd0,
    EEW16 = 2'd1,
    EEW32 = 2'd2,
    EEW1  = 2'd3
  } EEW_e;

  typedef enum logic [2:0] {
    ALU = 3'd0,
    MUL = 3'd1,
    DIV = 3'd2,
    CMP = 3'd3,
    RDT = 3'd4,
    PMT = 3'd5,
    LSU = 3'd6
  } EXE_UNIT_e;
endpackage

interface rvv_backend_dispatch_uop_seq_if #(
  parameter int VLEN            = 128,
  parameter int UOP_INDEX_WIDTH = 3,
  parameter int VL_WIDTH        = 8,
  parameter int VSTART_WIDTH    = 7
) ();
  import rvv_uop_seq_pkg::*;

  logic                       flush;

  logic                       inst_valid;
  logic                       inst_ready;
  logic [UOP_INDEX_WIDTH-1:0] inst_uop_cnt;
  EEW_e                       inst_vs1_eew;
  EEW_e                       inst_vs2_eew;
  EEW_e                       inst_vd_eew;
  EXE_UNIT_e                  inst_exe_unit;
  logic [VL_WIDTH-1:0]        inst_vl;
  logic [VSTART_WIDTH-1:0]    inst_vstart;
  logic                       inst_vm;
  logic                       inst_ignore_vta;
  logic                       inst_ignore_vma;
  logic [VLEN-1:0]            v0_in;

  logic                       uop_valid;
  logic                       uop_ready;
  logic [UOP_INDEX_WIDTH-1:0] uop_index;
  logic                       uop_last;
  EEW_e                       uop_vs1_eew;
  EEW_e                       uop_vs2_eew;
  EEW_e                       uop_vd_eew;
  EXE_UNIT_e                  uop_exe_unit;
  logic [VL_WIDTH-1:0]        uop_vl;
  logic [VSTART_WIDTH-1:0]    uop_vstart;
  logic                       uop_vm;
  logic                       uop_ignore_vta;
  logic                       uop_ignore_vma;
  logic [VLEN-1:0]            uop_v0;

  logic                       busy;

  modport slave (
    input  flush,
    input  inst_valid, inst_uop_cnt, inst_vs1_eew, inst_vs2_eew, inst_vd_eew,
           inst_exe_unit, inst_vl, inst_vstart, inst_vm, inst_ignore_vta,
           inst_ignore_vma, v0_in,
    output inst_ready,
    input  uop_ready,
    output uop_valid, uop_index, uop_last, uop_vs1_eew, uop_vs2_eew, uop_vd_eew,
           uop_exe_unit, uop_vl, uop_vstart, uop_vm, uop_ignore_vta,
           uop_ignore_vma, uop_v0,
    output busy
  );

  modport master (
    output flush,
    output inst_valid, inst_uop_cnt, inst_vs1_eew, inst_vs2_eew, inst_vd_eew,
           inst_exe_unit, inst_vl, inst_vstart, inst_vm, inst_ignore_vta,
           inst_ignore_vma, v0_in,
    input  inst_ready,
    output uop_ready,
    input  uop_valid, uop_index, uop_last, uop_vs1_eew, uop_vs2_eew, uop_vd_eew,
           uop_exe_unit, uop_vl, uop_vstart, uop_vm, uop_ignore_vta,
           uop_ignore_vma, uop_v0,
    input  busy
  );
endinterface

// File: rtl/rvv_backend_dispatch_uop_seq.sv
// Dispatch uop sequencer. It takes one decoded vector instruction and its v0
// snapshot, then presents the instruction's uops one per handshake with an
// incrementing index. Leading uops whose elements all lie below vstart are
// skipped when SKIP_PRESTART is set. The last uop is never skipped.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset.
//   io (slave) : flush, the descriptor handshake (inst_*, v0_in), the uop
//                handshake with its registered payload (uop_*), and busy.
module rvv_backend_dispatch_uop_seq
  import rvv_uop_seq_pkg::*;
#(
  parameter int VLEN            = 128,
  parameter int UOP_INDEX_WIDTH = 3,
  parameter int VL_WIDTH        = 8,
  parameter int VSTART_WIDTH    = 7,
  parameter int SKIP_PRESTART   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  rvv_backend_dispatch_uop_seq_if.slave io
);

  localparam int LOG2_VLENB = $clog2(VLEN / 8);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  state_e                     state_p1, state_nxt;
  logic [UOP_INDEX_WIDTH-1:0] idx_p1, idx_nxt;
  logic [UOP_INDEX_WIDTH-1:0] uop_cnt_p1;
  logic [UOP_INDEX_WIDTH-1:0] first_idx;
  logic                       at_last;
  logic                       accept;

  // The widest operand EEW sets how many elements fit in one uop.
  function automatic logic [1:0] eew_max_shift(input EEW_e a, input EEW_e b, input EEW_e c);
    if (a == EEW32 || b == EEW32 || c == EEW32) return 2'd2;
    else if (a == EEW16 || b == EEW16 || c == EEW16) return 2'd1;
    else return 2'd0;
  endfunction

  // Index of the first uop holding any element at or above vstart, capped at
  // the last uop so that an instruction always emits at least one uop.
  function automatic logic [UOP_INDEX_WIDTH-1:0] prestart_idx(
    input logic [VSTART_WIDTH-1:0]    vstart,
    input logic [1:0]                 max_shift,
    input logic [UOP_INDEX_WIDTH-1:0] cnt
  );
    logic [4:0]              epu_shift;
    logic [VSTART_WIDTH-1:0] uop_of_vstart;
    logic [VSTART_WIDTH-1:0] cnt_ext;
    epu_shift     = 5'(LOG2_VLENB) - 5'(max_shift);
    uop_of_vstart = vstart >> epu_shift;
    cnt_ext       = VSTART_WIDTH'(cnt);
    if (uop_of_vstart < cnt_ext) return uop_of_vstart[UOP_INDEX_WIDTH-1:0];
    else return cnt;
  endfunction

  always_comb begin
    if (SKIP_PRESTART == 0 || io.inst_exe_unit == RDT ||
        (io.inst_ignore_vta && io.inst_ignore_vma)) begin
      first_idx = '0;
    end else begin
      first_idx = prestart_idx(io.inst_vstart,
                               eew_max_shift(io.inst_vs1_eew, io.inst_vs2_eew, io.inst_vd_eew),
                               io.inst_uop_cnt);
    end
  end

  assign at_last       = (idx_p1 == uop_cnt_p1);
  assign io.inst_ready = !io.flush &&
                         (state_p1 == IDLE || (io.uop_ready && at_last));
  assign accept        = io.inst_valid && io.inst_ready;

  always_comb begin
    state_nxt = state_p1;
    idx_nxt   = idx_p1;
    if (io.flush) begin
      state_nxt = IDLE;
    end else if (accept) begin
      state_nxt = ISSUE;
      idx_nxt   = first_idx;
    end else if (state_p1 == ISSUE && io.uop_ready) begin
      if (at_last) state_nxt = IDLE;
      else idx_nxt = idx_p1 + 1'b1;
    end
  end

  // ---- stage p1: sequencer state and descriptor snapshot ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1          <= IDLE;
      idx_p1            <= '0;
      uop_cnt_p1        <= '0;
      io.uop_vs1_eew    <= EEW8;
      io.uop_vs2_eew    <= EEW8;
      io.uop_vd_eew     <= EEW8;
      io.uop_exe_unit   <= ALU;
      io.uop_vl         <= '0;
      io.uop_vstart     <= '0;
      io.uop_vm         <= 1'b0;
      io.uop_ignore_vta <= 1'b0;
      io.uop_ignore_vma <= 1'b0;
      io.uop_v0         <= '0;
    end else begin
      state_p1 <= state_nxt;
      idx_p1   <= idx_nxt;
      if (accept) begin
        uop_cnt_p1        <= io.inst_uop_cnt;
        io.uop_vs1_eew    <= io.inst_vs1_eew;
        io.uop_vs2_eew    <= io.inst_vs2_eew;
        io.uop_vd_eew     <= io.inst_vd_eew;
        io.uop_exe_unit   <= io.inst_exe_unit;
        io.uop_vl         <= io.inst_vl;
        io.uop_vstart     <= io.inst_vstart;
        io.uop_vm         <= io.inst_vm;
        io.uop_ignore_vta <= io.inst_ignore_vta;
        io.uop_ignore_vma <= io.inst_ignore_vma;
        io.uop_v0         <= io.v0_in;
      end
    end
  end

  assign io.uop_valid = (state_p1 == ISSUE);
  assign io.busy      = (state_p1 == ISSUE);
  assign io.uop_index = idx_p1;
  assign io.uop_last  = (state_p1 == ISSUE) && at_last;

endmodule

// File: doc/rvv_backend_dispatch_uop_seq.md
# rvv_backend_dispatch_uop_seq

Sequences one decoded vector instruction into its per-uop dispatch requests ahead of the dispatch operand byte-type generator. It accepts an instruction descriptor over a valid/ready handshake, snapshots the v0 mask, and emits uops one at a time with an incrementing `uop_index`. When enabled, it skips leading uops that lie entirely below `vstart`. Each emitted uop carries the stable mask snapshot and per-uop fields that the byte-type generator and the PU/RT stages consume.

## Interface
- `VLEN`, 128: vector register length in bits; `VLENB` = VLEN/8.
- `UOP_INDEX_WIDTH`, 3: width of `uop_index`; up to 8 uops per instruction.
- `VL_WIDTH`, 8: width of `vl`.
- `VSTART_WIDTH`, 7: width of `vstart`.
- `SKIP_PRESTART`, 1: 1 enables skipping of fully-prestart uops.
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `flush` input 1: synchronous kill; dominates every other input.
- `inst_valid` input 1: descriptor valid.
- `inst_ready` output 1: descriptor accepted when `inst_valid & inst_ready`.
- `inst_uop_cnt` input UOP_INDEX_WIDTH: number of uops minus 1.
- `inst_vs1_eew`, `inst_vs2_eew`, `inst_vd_eew` input EEW_e: operand EEWs.
- `inst_exe_unit` input EXE_UNIT_e: target unit; RDT is never skipped.
- `inst_vl` input VL_WIDTH; `inst_vstart` input VSTART_WIDTH; `inst_vm` input 1.
- `inst_ignore_vta`, `inst_ignore_vma` input 1.
- `v0_in` input VLEN: current v0 value; sampled only at descriptor accept.
- `uop_valid` output 1; `uop_ready` input 1: uop handshake.
- `uop_index` output UOP_INDEX_WIDTH: index of the presented uop.
- `uop_last` output 1: presented uop is the final uop of the instruction.
- `uop_vs1_eew`, `uop_vs2_eew`, `uop_vd_eew`, `uop_exe_unit`, `uop_vl`, `uop_vstart`, `uop_vm`, `uop_ignore_vta`, `uop_ignore_vma`: registered copies of the descriptor.
- `uop_v0` output VLEN: registered v0 snapshot.
- `busy` output 1: high whenever state is ISSUE.

## Operation
- States:
  - IDLE: no uop outstanding.
  - ISSUE: a uop is being presented.
- IDLE behaviour:
  - `inst_ready`=1.
  - On accept, register all descriptor fields and `v0_in`, load the index counter with `first_idx`, and go to ISSUE.
- ISSUE behaviour:
  - `uop_valid`=1. `uop_index`, `uop_last` and all payload outputs stay stable until the uop is accepted.
  - On `uop_ready` with `uop_last`=0, increment the index.
  - On `uop_ready` with `uop_last`=1: if `inst_valid`, accept the next descriptor in the same cycle (`inst_ready`=1 in that cycle) and stay in ISSUE; otherwise go to IDLE.
- `inst_ready` = IDLE | (ISSUE & `uop_ready` & `uop_last`) while `flush`=0. It is 0 whenever `flush`=1.
- eew_max_shift is decided by priority across vs1/vs2/vd:
  - any EEW32 gives 2;
  - else any EEW16 gives 1;
  - else 0.
- Elements per uop = VLENB >> eew_max_shift, so epu_shift = log2(VLENB) − eew_max_shift.
- `first_idx` rules:
  - 0 if `SKIP_PRESTART`=0, or exe unit is RDT, or both ignore_vta and ignore_vma are set.
  - Otherwise min(vstart >> epu_shift, uop_cnt).
- The last uop is never skipped.
- `uop_last` = (index == registered uop_cnt).
- `uop_vstart` passes the original vstart unchanged. The byte-type generator resolves prestart within a uop.
- `flush` in any state: next state IDLE, `uop_valid` drops the next cycle, and any simultaneous descriptor is not accepted.
- Registered payload and `uop_v0` keep their values in IDLE (no clear).

## Timing
- Reset values:
  - state IDLE;
  - `uop_valid`=0, `busy`=0, `uop_index`=0, `uop_last`=0;
  - all payload registers and `uop_v0` = 0;
  - `inst_ready`=1 (combinational from IDLE).
- Latency: a descriptor accepted at edge T presents its first uop at T+1.
- An N-uop instruction with no stalls and no skip occupies N cycles of `uop_valid`.
- Back-to-back instructions produce no bubble.
- `uop_valid` never deasserts without a handshake, except on `flush` or reset.
- `v0_in` changes after accept have no effect on `uop_v0`.
- Reset mid-instruction: all outputs return to reset values asynchronously; no partial uop is emitted after deassertion.

## Test plan
- Single instruction:
  - Stimulus: `uop_cnt`=3, all EEW32, vstart=0, `uop_ready` held 1.
  - Required: `uop_index` 0,1,2,3 on cycles T+1..T+4; `uop_last` only at index 3; then IDLE.
- Prestart skip:
  - Stimulus: EEW8, VLENB=16, `uop_cnt`=7, vstart=37.
  - Required: first `uop_index`=2; six uops total; `uop_vstart`=37.
- RDT and clamping:
  - Stimulus 1: RDT, vstart=37.
  - Required: first index 0.
  - Stimulus 2: non-RDT, EEW32, vstart=100, `uop_cnt`=3.
  - Required: clamps to index 3, with `uop_last`=1 on the first uop.
- Backpressure and snapshot:
  - Stimulus: `uop_ready`=0 for 5 cycles on index 1; toggle `v0_in` during the stall.
  - Required: index, payload and `uop_v0` unchanged; `inst_ready`=0 throughout.
- Back-to-back with flush:
  - Stimulus: second descriptor valid during the last-uop handshake.
  - Required: accepted that cycle and its index 0 presented the next cycle.
  - Stimulus: then assert `flush` at index 1.
  - Required: `uop_valid`=0 the next cycle, IDLE, and a simultaneous `inst_valid` is not accepted.
- Async reset:
  - Stimulus: `rst_n` low mid-ISSUE, asynchronous to `clk`.
  - Required: `uop_valid`=0 and `busy`=0 immediately, before the next clock edge.
